// File: rtl/lsu.sv
// hxd32 load/store unit: one data-bus transaction per request,
// with lane alignment, byte enables, load extension and fault detection.
module lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            lsu_req_i,
    input  logic            lsu_we_i,
    input  logic [2:0]      lsu_size_i,
    input  logic [XLEN-1:0] lsu_addr_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    output logic            lsu_busy_o,
    output logic            lsu_done_o,
    output logic            lsu_misalign_o,
    output logic [XLEN-1:0] lsu_rdata_o,
    output logic            dbus_req_o,
    output logic            dbus_we_o,
    output logic [3:0]      dbus_be_o,
    output logic [XLEN-1:0] dbus_addr_o,
    output logic [XLEN-1:0] dbus_wdata_o,
    input  logic            dbus_gnt_i,
    input  logic            dbus_rvalid_i,
    input  logic [XLEN-1:0] dbus_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t          state;
    logic            we_q;
    logic [2:0]      size_q;
    logic [1:0]      off_q;
    logic            fault;
    logic [3:0]      be_n;
    logic [XLEN-1:0] wdata_n;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] ext;

    // Stall upstream while a request is outstanding.
    assign lsu_busy_o = lsu_req_i & ~lsu_done_o;

    // Misaligned, reserved or store-unsigned encodings fault.
    always_comb begin
        fault = 1'b0;
        case (lsu_size_i)
            3'b000:  fault = 1'b0;
            3'b001:  fault = lsu_addr_i[0];
            3'b010:  fault = |lsu_addr_i[1:0];
            3'b100:  fault = lsu_we_i;
            3'b101:  fault = lsu_we_i | lsu_addr_i[0];
            default: fault = 1'b1;
        endcase
    end

    // Byte enables and lane-replicated store data for the request.
    always_comb begin
        be_n    = 4'b1111;
        wdata_n = lsu_wdata_i;
        case (lsu_size_i[1:0])
            2'b00: begin
                be_n    = 4'b0001 << lsu_addr_i[1:0];
                wdata_n = {4{lsu_wdata_i[7:0]}};
            end
            2'b01: begin
                be_n    = 4'b0011 << lsu_addr_i[1:0];
                wdata_n = {2{lsu_wdata_i[15:0]}};
            end
            default: begin
                be_n    = 4'b1111;
                wdata_n = lsu_wdata_i;
            end
        endcase
    end

    // Align returned lane to bit 0 and sign/zero extend.
    always_comb begin
        shifted = dbus_rdata_i >> {off_q, 3'b000};
        ext     = shifted;
        case (size_q[1:0])
            2'b00:
                ext = {{(XLEN-8){~size_q[2] & shifted[7]}},
                       shifted[7:0]};
            2'b01:
                ext = {{(XLEN-16){~size_q[2] & shifted[15]}},
                       shifted[15:0]};
            default:
                ext = shifted;
        endcase
    end

    // Transaction sequencer with registered bus and result outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= IDLE;
            we_q           <= 1'b0;
            size_q         <= 3'b000;
            off_q          <= 2'b00;
            dbus_req_o     <= 1'b0;
            dbus_we_o      <= 1'b0;
            dbus_be_o      <= 4'b0000;
            dbus_addr_o    <= '0;
            dbus_wdata_o   <= '0;
            lsu_rdata_o    <= '0;
            lsu_done_o     <= 1'b0;
            lsu_misalign_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (lsu_req_i) begin
                        if (fault) begin
                            lsu_done_o     <= 1'b1;
                            lsu_misalign_o <= 1'b1;
                            state          <= DONE;
                        end else begin
                            we_q         <= lsu_we_i;
                            size_q       <= lsu_size_i;
                            off_q        <= lsu_addr_i[1:0];
                            dbus_req_o   <= 1'b1;
                            dbus_we_o    <= lsu_we_i;
                            dbus_be_o    <= be_n;
                            dbus_addr_o  <= {lsu_addr_i[XLEN-1:2], 2'b00};
                            dbus_wdata_o <= wdata_n;
                            state        <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dbus_gnt_i) begin
                        dbus_req_o <= 1'b0;
                        if (we_q) begin
                            lsu_done_o <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (dbus_rvalid_i) begin
                        lsu_rdata_o <= ext;
                        lsu_done_o  <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    lsu_done_o     <= 1'b0;
                    lsu_misalign_o <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
